pooling_engine: RTL and testbench

Datapath responder to the pooling controller. Consumes the replicated per-column `pooling_signal`/`input_flag_PL` strobes and the shared kernel/window counters, and reduces each column's convolution output stream to one max- or average-pooled value per window. Results are queued in a 4-deep result FIFO with valid/ready output. The block returns `out_flag_pooling` to the controller to request the next window once buffer space exists.

---
 rtl/pooling_engine.sv | 171 +++++++++++++++++
 tb/tb_pooling_engine.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_engine.sv
// pooling_engine: per-lane max/average pooling with a show-ahead result FIFO
// and a window-request handshake back to the pooling controller.
module pooling_engine #(
  parameter int COLS       = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS-1:0]        pooling_signal_i,
  input  logic [COLS-1:0]        input_flag_pl_i,
  input  logic [1:0]             cnt_pl_kernel_x,
  input  logic [1:0]             cnt_pl_kernel_y,
  input  logic [3:0]             cnt_pl_window,
  input  logic [2:0]             kernel_dim,
  input  logic                   pool_mode,
  input  logic [COLS*DATA_W-1:0] data_in,
  output logic                   out_flag_pooling,
  output logic                   pool_valid,
  input  logic                   pool_ready,
  output logic [COLS*DATA_W-1:0] pool_data,
  output logic [COLS-1:0]        pool_mask,
  output logic [3:0]             pool_win,
  output logic                   err_overflow,
  output logic                   err_avg_dim
);

  localparam int SUM_W = DATA_W + 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [COLS-1:0]        act;
  logic                   first_el;
  logic                   last_el;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   wr_en;
  logic                   fire;
  logic                   avg_sel;
  logic [2:0]             shamt;
  logic [COLS*DATA_W-1:0] res_data;

  logic [COLS*DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [COLS*DATA_W-1:0] data_mem_d [FIFO_DEPTH];
  logic [COLS-1:0]        mask_mem_q [FIFO_DEPTH];
  logic [COLS-1:0]        mask_mem_d [FIFO_DEPTH];
  logic [3:0]             win_mem_q  [FIFO_DEPTH];
  logic [3:0]             win_mem_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pending_q, pending_d;
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_avg_dim_q, err_avg_dim_d;

  // Window-position decode shared by all lanes; the push is keyed to lane 0.
  always_comb begin
    act      = pooling_signal_i & input_flag_pl_i;
    first_el = (cnt_pl_kernel_x == 2'd0) && (cnt_pl_kernel_y == 2'd0);
    last_el  = ({1'b0, cnt_pl_kernel_x} == kernel_dim - 3'd1) &&
               ({1'b0, cnt_pl_kernel_y} == kernel_dim - 3'd1);
    push     = act[0] && last_el;
    avg_sel  = pool_mode && (kernel_dim != 3'd3);
    case (kernel_dim)
      3'd2:    shamt = 3'd2;
      3'd4:    shamt = 3'd4;
      default: shamt = 3'd0;
    endcase
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] max_new, max_q, max_d;
    logic signed [SUM_W-1:0]  sum_new, sum_q, sum_d, avg_full;
    logic [DATA_W-1:0]        lane_res;

    // Both reductions run every strobe so dim-3 averages can fall back to max.
    always_comb begin
      sample   = data_in[c*DATA_W +: DATA_W];
      max_new  = (first_el || (sample > max_q)) ? sample : max_q;
      sum_new  = first_el ? {{4{sample[DATA_W-1]}}, sample}
                          : sum_q + {{4{sample[DATA_W-1]}}, sample};
      avg_full = sum_new >>> shamt;
      max_d    = act[c] ? max_new : max_q;
      sum_d    = act[c] ? sum_new : sum_q;
      if (!act[c])      lane_res = '0;
      else if (avg_sel) lane_res = avg_full[DATA_W-1:0];
      else              lane_res = max_new;
    end

    // Per-lane accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        max_q <= '0;
        sum_q <= '0;
      end else begin
        max_q <= max_d;
        sum_q <= sum_d;
      end
    end

    assign res_data[c*DATA_W +: DATA_W] = lane_res;
  end

  // FIFO bookkeeping, sticky errors and the pending window-request bit.
  always_comb begin
    full           = (count_q == CNT_W'(FIFO_DEPTH));
    pop            = (count_q != '0) && pool_ready;
    wr_en          = push && (!full || pop);
    fire           = pending_q && (count_q < CNT_W'(FIFO_DEPTH));
    data_mem_d     = data_mem_q;
    mask_mem_d     = mask_mem_q;
    win_mem_d      = win_mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    if (wr_en) begin
      data_mem_d[wr_ptr_q] = res_data;
      mask_mem_d[wr_ptr_q] = act;
      win_mem_d[wr_ptr_q]  = cnt_pl_window;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new push re-arms the request even on the cycle an older one fires.
    if (push)      pending_d = 1'b1;
    else if (fire) pending_d = 1'b0;
    else           pending_d = pending_q;
    err_overflow_d = err_overflow_q | (push & full & ~pop);
    err_avg_dim_d  = err_avg_dim_q | (push & pool_mode & (kernel_dim == 3'd3));
  end

  // FIFO storage, pointers and control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_mem_q     <= '{default: '0};
      mask_mem_q     <= '{default: '0};
      win_mem_q      <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pending_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      err_avg_dim_q  <= 1'b0;
    end else begin
      data_mem_q     <= data_mem_d;
      mask_mem_q     <= mask_mem_d;
      win_mem_q      <= win_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pending_q      <= pending_d;
      err_overflow_q <= err_overflow_d;
      err_avg_dim_q  <= err_avg_dim_d;
    end
  end

  assign out_flag_pooling = fire;
  assign pool_valid       = (count_q != '0);
  assign pool_data        = data_mem_q[rd_ptr_q];
  assign pool_mask        = mask_mem_q[rd_ptr_q];
  assign pool_win         = win_mem_q[rd_ptr_q];
  assign err_overflow     = err_overflow_q;
  assign err_avg_dim      = err_avg_dim_q;

endmodule

// File: tb/tb_pooling_engine.sv
// Self-checking bench for pooling_engine against a plain-arithmetic model.
module tb_pooling_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pooling_signal_i;
  logic [3:0]  input_flag_pl_i;
  logic [1:0]  cnt_pl_kernel_x;
  logic [1:0]  cnt_pl_kernel_y;
  logic [3:0]  cnt_pl_window;
  logic [2:0]  kernel_dim;
  logic        pool_mode;
  logic [63:0] data_in;
  logic        out_flag_pooling;
  logic        pool_valid;
  logic        pool_ready;
  logic [63:0] pool_data;
  logic [3:0]  pool_mask;
  logic [3:0]  pool_win;
  logic        err_overflow;
  logic        err_avg_dim;

  pooling_engine #(.COLS(4), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pooling_signal_i(pooling_signal_i), .input_flag_pl_i(input_flag_pl_i),
    .cnt_pl_kernel_x(cnt_pl_kernel_x), .cnt_pl_kernel_y(cnt_pl_kernel_y),
    .cnt_pl_window(cnt_pl_window), .kernel_dim(kernel_dim), .pool_mode(pool_mode),
    .data_in(data_in), .out_flag_pooling(out_flag_pooling), .pool_valid(pool_valid),
    .pool_ready(pool_ready), .pool_data(pool_data), .pool_mask(pool_mask),
    .pool_win(pool_win), .err_overflow(err_overflow), .err_avg_dim(err_avg_dim)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;

  // Window-request pulses counted mid-cycle, away from the active edge.
  always @(negedge clk) if (out_flag_pooling === 1'b1) flag_cnt++;

  int samp [4][16];
  logic [63:0] exp_data;
  logic [3:0]  exp_mask;
  logic [3:0]  exp_win;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  m;
    logic [3:0]  w;
  } ent_t;
  ent_t exp_q[$];

  // Reference: max over the window, or floor(mean) for dims 1/2/4.
  function automatic logic [15:0] ref_lane(input int lane, input int dim, input bit mode);
    int n, mx, sum, q;
    n = dim * dim;
    mx = samp[lane][0];
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (samp[lane][i] > mx) mx = samp[lane][i];
      sum += samp[lane][i];
    end
    if (mode && dim != 3) begin
      q = sum / n;
      if ((sum % n) != 0 && sum < 0) q = q - 1;
      return q[15:0];
    end
    return mx[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pooling_signal_i = '0;
    input_flag_pl_i  = '0;
  endtask

  task automatic rand_samples();
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 16; i++)
        samp[l][i] = int'($urandom_range(65535)) - 32768;
  endtask

  // Drives one full window in raster order and records the model's result.
  task automatic drive_window(input int dim, input bit mode, input logic [3:0] lanes,
                              input logic [3:0] win);
    logic [7:0] r;
    r = 8'($urandom);
    kernel_dim    = 3'(dim);
    pool_mode     = mode;
    cnt_pl_window = win;
    for (int i = 0; i < dim * dim; i++) begin
      cnt_pl_kernel_x  = 2'(i % dim);
      cnt_pl_kernel_y  = 2'(i / dim);
      pooling_signal_i = lanes | r[3:0];
      input_flag_pl_i  = lanes | (r[7:4] & ~r[3:0]);
      for (int c = 0; c < 4; c++) data_in[c*16 +: 16] = 16'(samp[c][i]);
      step();
    end
    exp_data = '0;
    for (int c = 0; c < 4; c++)
      if (lanes[c]) exp_data[c*16 +: 16] = ref_lane(c, dim, mode);
    exp_mask = lanes;
    exp_win  = win;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pool_ready = 1'b0;
    idle();
    cnt_pl_kernel_x = '0; cnt_pl_kernel_y = '0; cnt_pl_window = '0;
    kernel_dim = 3'd2; pool_mode = 1'b0; data_in = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++;
    if ({pool_valid, out_flag_pooling, err_overflow, err_avg_dim} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {pool_valid, out_flag_pooling, err_overflow, err_avg_dim});
    end
    checks++;
    if ({pool_mask, pool_win} !== 8'h00) begin
      errors++;
      $display("FAIL reset_tag: got %h expected 00", {pool_mask, pool_win});
    end
    checks++;
    if (pool_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", pool_data);
    end
  endtask

  task automatic test_max();
    pool_ready = 1'b1;
    rand_samples();
    samp[0][0] = 3; samp[0][1] = -7; samp[0][2] = 9; samp[0][3] = 2;
    drive_window(2, 1'b0, 4'hF, 4'd5);
    idle();
    checks++;
    if (pool_valid !== 1'b1) begin
      errors++;
      $display("FAIL max_valid: got %b expected 1", pool_valid);
    end
    checks++;
    if (out_flag_pooling !== 1'b1) begin
      errors++;
      $display("FAIL max_flag: got %b expected 1", out_flag_pooling);
    end
    checks++;
    if (pool_data[15:0] !== 16'd9) begin
      errors++;
      $display("FAIL max_lane0: got %0d expected 9", $signed(pool_data[15:0]));
    end
    checks++;
    if (pool_data !== exp_data) begin
      errors++;
      $display("FAIL max_data: got %h expected %h", pool_data, exp_data);
    end
    checks++;
    if ({pool_mask, pool_win} !== {4'hF, 4'd5}) begin
      errors++;
      $display("FAIL max_tag: got %h expected f5", {pool_mask, pool_win});
    end
    step();
    checks++;
    if ({pool_valid, out_flag_pooling} !== 2'b00) begin
      errors++;
      $display("FAIL max_pulse_end: got %b expected 00", {pool_valid, out_flag_pooling});
    end
  endtask

  task automatic test_avg();
    pool_ready = 1'b1;
    rand_samples();
    samp[0][0] = 4; samp[0][1] = 8; samp[0][2] = -4; samp[0][3] = 12;
    drive_window(2, 1'b1, 4'hF, 4'd1);
    idle();
    checks++;
    if (pool_data[15:0] !== 16'd5) begin
      errors++;
      $display("FAIL avg2_lane0: got %0d expected 5", $signed(pool_data[15:0]));
    end
    checks++;
    if (pool_data !== exp_data) begin
      errors++;
      $display("FAIL avg2_data: got %h expected %h", pool_data, exp_data);
    end
    step();
    for (int l = 0; l < 4; l++) for (int i = 0; i < 16; i++) samp[l][i] = 16;
    drive_window(4, 1'b1, 4'hF, 4'd2);
    idle();
    checks++;
    if (pool_data !== 64'h0010_0010_0010_0010) begin
      errors++;
      $display("FAIL avg4_data: got %h expected 0010001000100010", pool_data);
    end
    checks++;
    if (err_avg_dim !== 1'b0) begin
      errors++;
      $display("FAIL avg_err_early: got %b expected 0", err_avg_dim);
    end
    step();
    rand_samples();
    drive_window(3, 1'b1, 4'hF, 4'd3);
    idle();
    checks++;
    if (pool_data !== exp_data) begin
      errors++;
      $display("FAIL avg3_data: got %h expected %h", pool_data, exp_data);
    end
    checks++;
    if (err_avg_dim !== 1'b1) begin
      errors++;
      $display("FAIL avg3_err: got %b expected 1", err_avg_dim);
    end
    step();
  endtask

  task automatic test_dim1_stream();
    int base;
    pool_ready = 1'b1;
    base = flag_cnt;
    for (int k = 1; k <= 6; k++) begin
      rand_samples();
      samp[0][0] = k;
      drive_window(1, 1'b0, 4'hF, 4'(8 + k));
      checks++;
      if (pool_valid !== 1'b1) begin
        errors++;
        $display("FAIL d1_valid_%0d: got %b expected 1", k, pool_valid);
      end
      checks++;
      if (pool_data[15:0] !== 16'(k)) begin
        errors++;
        $display("FAIL d1_lane0_%0d: got %0d expected %0d", k, pool_data[15:0], k);
      end
      checks++;
      if (pool_win !== 4'(8 + k)) begin
        errors++;
        $display("FAIL d1_win_%0d: got %0d expected %0d", k, pool_win, 8 + k);
      end
      checks++;
      if (pool_data !== exp_data) begin
        errors++;
        $display("FAIL d1_data_%0d: got %h expected %h", k, pool_data, exp_data);
      end
    end
    idle();
    repeat (3) step();
    checks++;
    if (flag_cnt - base !== 6) begin
      errors++;
      $display("FAIL d1_flags: got %0d expected 6", flag_cnt - base);
    end
  endtask

  task automatic test_overflow();
    int base;
    ent_t e;
    rst = 1'b1; step(); rst = 1'b0; step();
    pool_ready = 1'b0;
    exp_q.delete();
    base = flag_cnt;
    for (int w = 0; w < 5; w++) begin
      rand_samples();
      drive_window(2, bit'($urandom_range(1)), 4'hF, 4'(w));
      if (w < 4) begin
        e = {exp_data, exp_mask, exp_win};
        exp_q.push_back(e);
      end
      idle();
      repeat (2) step();
    end
    checks++;
    if (flag_cnt - base !== 3) begin
      errors++;
      $display("FAIL ovf_flags: got %0d expected 3", flag_cnt - base);
    end
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err: got %b expected 1", err_overflow);
    end
    checks++;
    if (out_flag_pooling !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag_held: got %b expected 0", out_flag_pooling);
    end
    base = flag_cnt;
    for (int n = 0; n < 4; n++) begin
      e = exp_q.pop_front();
      checks++;
      if ({pool_valid, pool_data, pool_mask, pool_win} !== {1'b1, e.d, e.m, e.w}) begin
        errors++;
        $display("FAIL ovf_head_%0d: got %b %h %h %h expected 1 %h %h %h",
                 n, pool_valid, pool_data, pool_mask, pool_win, e.d, e.m, e.w);
      end
      pool_ready = 1'b1;
      step();
      pool_ready = 1'b0;
      if (n == 0) begin
        checks++;
        if (out_flag_pooling !== 1'b1) begin
          errors++;
          $display("FAIL ovf_pop_flag: got %b expected 1", out_flag_pooling);
        end
        step();
        checks++;
        if (flag_cnt - base !== 1) begin
          errors++;
          $display("FAIL ovf_pop_once: got %0d expected 1", flag_cnt - base);
        end
      end
    end
    checks++;
    if (pool_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: got %b expected 0", pool_valid);
    end
  endtask

  task automatic test_mask();
    pool_ready = 1'b1;
    rand_samples();
    drive_window(2, 1'b0, 4'b0101, 4'd7);
    idle();
    checks++;
    if (pool_mask !== 4'b0101) begin
      errors++;
      $display("FAIL mask_bits: got %b expected 0101", pool_mask);
    end
    checks++;
    if ({pool_data[63:48], pool_data[31:16]} !== 32'h0) begin
      errors++;
      $display("FAIL mask_zero: got %h expected 0", {pool_data[63:48], pool_data[31:16]});
    end
    checks++;
    if (pool_data !== exp_data) begin
      errors++;
      $display("FAIL mask_data: got %h expected %h", pool_data, exp_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    pool_ready = 1'b0;
    rand_samples();
    drive_window(2, 1'b0, 4'hF, 4'd1);
    idle();
    step();
    rand_samples();
    kernel_dim = 3'd2;
    pool_mode  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt_pl_kernel_x = 2'(i); cnt_pl_kernel_y = 2'd0;
      pooling_signal_i = 4'hF; input_flag_pl_i = 4'hF;
      for (int c = 0; c < 4; c++) data_in[c*16 +: 16] = 16'(samp[c][i] + 7);
      step();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pool_valid, out_flag_pooling, err_overflow, err_avg_dim, pool_mask, pool_win} !== '0) begin
      errors++;
      $display("FAIL rstmid_ctrl: got %b expected 0",
               {pool_valid, out_flag_pooling, err_overflow, err_avg_dim, pool_mask, pool_win});
    end
    checks++;
    if (pool_data !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_data: got %h expected 0", pool_data);
    end
    step();
    rst = 1'b0;
    step();
    pool_ready = 1'b1;
    rand_samples();
    drive_window(2, 1'b1, 4'hF, 4'd9);
    idle();
    checks++;
    if ({pool_valid, pool_data, pool_win} !== {1'b1, exp_data, 4'd9}) begin
      errors++;
      $display("FAIL rstmid_fresh: got %b %h %h expected 1 %h 9", pool_valid, pool_data, pool_win, exp_data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int dims [3] = '{1, 2, 4};
    int dim;
    bit mode;
    logic [3:0] lanes, win;
    pool_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      dim   = dims[$urandom_range(2)];
      mode  = bit'($urandom_range(1));
      lanes = 4'($urandom) | 4'b0001;
      win   = 4'($urandom);
      rand_samples();
      drive_window(dim, mode, lanes, win);
      checks++;
      if ({pool_valid, pool_data, pool_mask, pool_win} !== {1'b1, exp_data, exp_mask, exp_win}) begin
        errors++;
        $display("FAIL b2b_%0d: got %b %h %h %h expected 1 %h %h %h (dim %0d mode %0d)",
                 n, pool_valid, pool_data, pool_mask, pool_win, exp_data, exp_mask, exp_win, dim, mode);
      end
    end
    idle();
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_dim1_stream();
    test_mask();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
